result_bcd_reader: RTL and testbench

//  Reader side of the 16-bit signed result register: consumes the stored two's-complement

---
 rtl/result_bcd_reader.sv | 90 +++++++++
 tb/tb_result_bcd_reader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/result_bcd_reader.sv
// rtl/result_bcd_reader.sv - signed result register to sign + packed BCD, iterative double-dabble
module result_bcd_reader #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt;
   logic [WIDTH-1:0]    mag;
   logic                sign;
   logic [4*DIGITS-1:0] scratch, adjusted, shifted;
   logic                accept, last_iter;

   assign accept    = start && (state == IDLE || state == DONE);
   assign last_iter = (state == CONV) && (cnt == CW'(WIDTH - 1));
   assign busy      = (state == CONV);
   assign done      = (state == DONE);

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONV;
         CONV:    if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = start ? CONV : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add-3 on every digit >= 5, then shift the next magnitude bit into digit 0.
   always_comb begin
      adjusted = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         else                           adjusted[4*d +: 4] = scratch[4*d +: 4];
      end
      shifted = {adjusted[4*DIGITS-2:0], mag[WIDTH-1]};
   end

   // An unsigned WIDTH-bit magnitude already holds 2**(WIDTH-1), so -min needs no extra bit.
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt     <= '0;
         mag     <= '0;
         sign    <= 1'b0;
         scratch <= '0;
         bcd     <= '0;
         neg     <= 1'b0;
      end else if (accept) begin
         sign    <= value[WIDTH-1];
         mag     <= value[WIDTH-1] ? (~value + 1'b1) : value;
         scratch <= '0;
         cnt     <= '0;
      end else if (state == CONV) begin
         scratch <= shifted;
         mag     <= {mag[WIDTH-2:0], 1'b0};
         cnt     <= cnt + CW'(1);
         if (last_iter) begin
            bcd <= shifted;
            neg <= sign;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr && state == CONV) begin
         for (int d = 0; d < DIGITS; d++) begin
            assert (scratch[4*d +: 4] <= 4'd9);
         end
      end
   end

endmodule

// File: tb/tb_result_bcd_reader.sv
// tb/tb_result_bcd_reader.sv - directed and sampled-sweep bench for result_bcd_reader
module tb_result_bcd_reader;

   logic        clk = 1'b0;
   logic        clr, start;
   logic [15:0] value;
   logic        busy, done, neg;
   logic [19:0] bcd;

   int pass_cnt  = 0;
   int total     = 0;
   int cycle     = 0;
   int acc_cycle = 0;
   int d1        = 0;

   result_bcd_reader #(.WIDTH(16), .DIGITS(5)) dut (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .value (value),
      .busy  (busy),
      .done  (done),
      .neg   (neg),
      .bcd   (bcd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [19:0] ref_bcd(input logic [15:0] v);
      int sv;
      int m;
      logic [19:0] r;
      sv = {{16{v[15]}}, v};
      m  = (sv < 0) ? -sv : sv;
      r  = '0;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   task automatic kick(input logic [15:0] v, input logic hold);
      @(negedge clk);
      value = v;
      start = 1'b1;
      @(posedge clk);
      #1;
      acc_cycle = cycle;
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic [19:0] exp_bcd, input logic exp_neg);
      int k;
      k = 0;
      while (!done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_lat"}, cycle - acc_cycle, 32'd16);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, exp_bcd});
      chk({tag, "_neg"}, {31'd0, neg}, {31'd0, exp_neg});
   endtask

   logic [15:0] edge_vals [10] = '{16'd0, 16'd1, 16'hFFFF, 16'd9, 16'd10, 16'd99,
                                    16'd10000, 16'hD8F0, 16'h8001, 16'd5};

   initial begin
      clr   = 1'b1;
      start = 1'b0;
      value = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_neg", {31'd0, neg}, 32'd0);
      chk("rst_bcd", {12'd0, bcd}, 32'd0);
      clr = 1'b0;

      // 1: basic conversion, busy for the whole window, single-cycle done
      kick(16'd12345, 1'b0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      repeat (8) @(posedge clk);
      #1;
      chk("t1_busy_mid", {31'd0, busy}, 32'd1);
      chk("t1_nopartial", {12'd0, bcd}, 32'd0);
      wait_done("t1", 20'h12345, 1'b0);
      @(posedge clk);
      #1;
      chk("t1_pulse", {31'd0, done}, 32'd0);

      // 2: extremes
      kick(16'h8000, 1'b0);
      wait_done("t2_min", 20'h32768, 1'b1);
      kick(16'h7FFF, 1'b0);
      wait_done("t2_max", 20'h32767, 1'b0);

      // 3: -1 then zero
      kick(16'hFFFF, 1'b0);
      wait_done("t3_m1", 20'h00001, 1'b1);
      kick(16'd0, 1'b0);
      wait_done("t3_zero", 20'h00000, 1'b0);

      // 4: start during conversion is ignored
      kick(16'd12345, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      value = 16'd999;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t4_busy", {31'd0, busy}, 32'd1);
      chk("t4_hold", {12'd0, bcd}, 32'h00000);
      wait_done("t4", 20'h12345, 1'b0);

      // 5: clr mid-conversion discards everything
      kick(16'd4321, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_done", {31'd0, done}, 32'd0);
      chk("t5_bcd", {12'd0, bcd}, 32'd0);
      chk("t5_neg", {31'd0, neg}, 32'd0);
      kick(16'hFF06, 1'b0);
      wait_done("t5_m250", 20'h00250, 1'b1);

      // 6: start held -> back-to-back accepts, done every 17 cycles
      kick(16'd100, 1'b1);
      value = 16'd7777;
      wait_done("t6_a", 20'h00100, 1'b0);
      d1 = cycle;
      value = 16'd200;
      @(posedge clk);
      #1;
      start = 1'b0;
      acc_cycle = cycle;
      chk("t6_reaccept", {31'd0, busy}, 32'd1);
      wait_done("t6_b", 20'h00200, 1'b0);
      chk("t6_period", cycle - d1, 32'd17);

      // boundary table and a random sample against the decimal reference
      foreach (edge_vals[i]) begin
         kick(edge_vals[i], 1'b0);
         wait_done("edge", ref_bcd(edge_vals[i]), edge_vals[i][15]);
      end
      for (int i = 0; i < 120; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         kick(v, 1'b0);
         wait_done("rand", ref_bcd(v), v[15]);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
